// File: rtl/reduction_seq.sv
// reduction_seq: iteration sequencer that drives a phase_a stage NUM_ITER times,
// feeding each new_a back in as the next a, and returns the final value with
// a one-cycle done pulse. A per-pass watchdog aborts the operation if phase_a
// never answers.
//
// Handshake with phase_a: pa_en is a single-cycle request pulse. pa_a is held
// stable from that pulse until the matching pa_en_out pulse. pa_en_out is a
// single-cycle completion pulse. pa_new_a is valid only while pa_en_out=1, and
// it is accepted only in WAIT. A completion pulse seen in any other state is
// ignored.
module reduction_seq #(
  parameter int Size     = 3072,
  parameter int NUM_ITER = 29,
  parameter int TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [Size-1:0] a_in,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [Size-1:0] result,
  output logic [Size-1:0] pa_a,
  output logic            pa_en,
  input  logic            pa_en_out,
  input  logic [Size-1:0] pa_new_a,
  output logic [2:0]      state_dbg
);

  localparam int IW = $clog2(NUM_ITER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [Size-1:0] work;
  logic [IW-1:0]   iter;
  logic [TW-1:0]   timer;
  logic            err_flag;

  logic last_pass;
  logic timed_out;

  // Operand to phase_a is the work register itself, so it cannot glitch mid-pass.
  assign pa_a      = work;
  // err is only meaningful alongside done; both come from registers.
  assign err       = done & err_flag;
  assign state_dbg = state;

  // Pass/timeout decodes used in WAIT.
  assign last_pass = (iter == IW'(NUM_ITER - 1));
  assign timed_out = (timer == TW'(TIMEOUT - 1));

  // Sequencer FSM with registered outputs (pa_en, busy, done, result).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      work     <= '0;
      iter     <= '0;
      timer    <= '0;
      err_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pa_en    <= 1'b0;
      result   <= '0;
    end else begin
      pa_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            work  <= a_in;
            iter  <= '0;
            busy  <= 1'b1;
            pa_en <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          // A completion in the timeout cycle still counts as a capture.
          if (pa_en_out) begin
            work <= pa_new_a;
            iter <= iter + IW'(1);
            if (last_pass) begin
              result <= pa_new_a;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_GAP;
            end
          end else if (timed_out) begin
            err_flag <= 1'b1;
            result   <= work;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_GAP: begin
          // One low cycle so phase_a's edge detector sees en drop between passes.
          pa_en <= 1'b1;
          state <= S_ISSUE;
        end
        S_DONE: begin
          busy     <= 1'b0;
          err_flag <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reduction_seq.sv
// Bench for reduction_seq: two instances (3 and 29 passes) each driven by a
// behavioural phase_a model; expected pa_a values and {err,result} pairs are
// queued when stimulus is issued and popped by an independent monitor.
module tb_reduction_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]   start_v;
  logic [W-1:0] a_in_v [2];
  logic [1:0]   busy_v, done_v, err_v, pa_en_v, pa_en_out_v;
  logic [W-1:0] result_v [2];
  logic [W-1:0] pa_a_v [2];
  logic [W-1:0] pa_new_a_v [2];
  logic [2:0]   st_v [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard queues: expected pa_a per request, expected {err,result} per done.
  logic [W-1:0] pa_q0[$];
  logic [W-1:0] pa_q1[$];
  logic [W:0]   exp_q0[$];
  logic [W:0]   exp_q1[$];

  // Model controls (written by the stimulus process).
  int           lat [2];
  int           mute_at [2];
  int           inj_cnt [2];
  logic [W-1:0] inj_val [2];

  // Model state.
  logic         m_act [2];
  int           m_rem [2];
  int           m_pcnt [2];
  int           inj_seen [2];

  // Monitor bookkeeping.
  int   start_cyc [2];
  int   done_cyc [2];
  int   last_pen_cyc [2];
  int   pen_cnt [2];
  int   low_cnt [2];
  logic pen_prev [2];
  logic pen_seen [2];

  reduction_seq #(.Size(W), .NUM_ITER(3), .TIMEOUT(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_in(a_in_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .result(result_v[0]),
    .pa_a(pa_a_v[0]), .pa_en(pa_en_v[0]), .pa_en_out(pa_en_out_v[0]),
    .pa_new_a(pa_new_a_v[0]), .state_dbg(st_v[0])
  );

  reduction_seq #(.Size(W), .NUM_ITER(29), .TIMEOUT(64)) dut29 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_in(a_in_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .result(result_v[1]),
    .pa_a(pa_a_v[1]), .pa_en(pa_en_v[1]), .pa_en_out(pa_en_out_v[1]),
    .pa_new_a(pa_new_a_v[1]), .state_dbg(st_v[1])
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural phase_a: answers new_a=a+1 at lat cycles after the ISSUE cycle,
  // optionally stays silent on one pass, and can inject a stray completion.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]       <= 1'b0;
        m_rem[i]       <= 0;
        m_pcnt[i]      <= 0;
        inj_seen[i]    <= inj_cnt[i];
        pa_en_out_v[i] <= 1'b0;
        pa_new_a_v[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        pa_en_out_v[i] <= 1'b0;
        if (inj_cnt[i] != inj_seen[i]) begin
          inj_seen[i]    <= inj_cnt[i];
          pa_en_out_v[i] <= 1'b1;
          pa_new_a_v[i]  <= inj_val[i];
        end else if (m_act[i]) begin
          if (m_rem[i] == 1) begin
            pa_en_out_v[i] <= 1'b1;
            pa_new_a_v[i]  <= pa_a_v[i] + W'(1);
            m_act[i]       <= 1'b0;
          end else begin
            m_rem[i] <= m_rem[i] - 1;
          end
        end
        if (pa_en_v[i]) begin
          m_pcnt[i] <= m_pcnt[i] + 1;
          if (m_pcnt[i] + 1 != mute_at[i]) begin
            m_act[i] <= 1'b1;
            m_rem[i] <= lat[i] - 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_pa(input int i, input logic [W-1:0] v);
    if (i == 0) pa_q0.push_back(v);
    else        pa_q1.push_back(v);
  endtask

  task automatic push_exp(input int i, input logic e, input logic [W-1:0] r);
    if (i == 0) exp_q0.push_back({e, r});
    else        exp_q1.push_back({e, r});
  endtask

  // Monitor: pops and compares whenever a DUT presents pa_en or done.
  initial begin
    for (int i = 0; i < 2; i++) begin
      pen_cnt[i] = 0; low_cnt[i] = 0; pen_prev[i] = 1'b0; pen_seen[i] = 1'b0;
      done_cyc[i] = 0; last_pen_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (pa_en_v[i]) begin
          logic [W-1:0] ev;
          int qs;
          check($sformatf("pa_en_width[%0d]", i), 64'(pen_prev[i]), 64'd0);
          if (pen_seen[i]) check($sformatf("pa_en_gap[%0d]", i), 64'(low_cnt[i] >= 2), 64'd1);
          qs = (i == 0) ? pa_q0.size() : pa_q1.size();
          if (qs == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pa_en[%0d]: got pa_a=0x%0h, expected no request", i, pa_a_v[i]);
          end else begin
            ev = (i == 0) ? pa_q0.pop_front() : pa_q1.pop_front();
            check($sformatf("pa_a[%0d]", i), 64'(pa_a_v[i]), 64'(ev));
          end
          pen_cnt[i]++;
          last_pen_cyc[i] = cyc;
          low_cnt[i] = 0;
          pen_seen[i] = 1'b1;
        end else begin
          low_cnt[i]++;
        end
        pen_prev[i] = pa_en_v[i];
        if (done_v[i]) begin
          logic [W:0] ex;
          int qs;
          qs = (i == 0) ? exp_q0.size() : exp_q1.size();
          if (qs == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done[%0d]: got err=%0b result=0x%0h, expected no done", i, err_v[i], result_v[i]);
          end else begin
            ex = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("err_result[%0d]", i), 64'({err_v[i], result_v[i]}), 64'(ex));
          end
          check($sformatf("busy_in_done[%0d]", i), 64'(busy_v[i]), 64'd1);
          done_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic start_op(input int i, input logic [W-1:0] a);
    a_in_v[i]    = a;
    start_v[i]   = 1'b1;
    start_cyc[i] = cyc;
    @(negedge clk);
    start_v[i]   = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (done_v[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_done[%0d]", i), 64'(done_v[i]), 64'd1);
    #1;
  endtask

  // Stimulus.
  initial begin
    int base;
    rst_n = 1'b0;
    start_v = '0;
    for (int i = 0; i < 2; i++) begin
      a_in_v[i] = '0; lat[i] = 18; mute_at[i] = 0; inj_cnt[i] = 0; inj_val[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset defaults held with start low.
    repeat (20) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_busy[%0d]", i),   64'(busy_v[i]),   64'd0);
      check($sformatf("rst_done[%0d]", i),   64'(done_v[i]),   64'd0);
      check($sformatf("rst_err[%0d]", i),    64'(err_v[i]),    64'd0);
      check($sformatf("rst_pa_en[%0d]", i),  64'(pa_en_v[i]),  64'd0);
      check($sformatf("rst_result[%0d]", i), 64'(result_v[i]), 64'd0);
      check($sformatf("rst_state[%0d]", i),  64'(st_v[i]),     64'd0);
    end

    // Normal: 3 passes, L=18, a=5 -> pa_a 5,6,7, result 8.
    lat[0] = 18;
    push_pa(0, 5); push_pa(0, 6); push_pa(0, 7);
    push_exp(0, 1'b0, 32'd8);
    base = pen_cnt[0];
    start_op(0, 32'd5);
    wait_done(0, 200);
    check("lat_3x18", 64'(done_cyc[0] - start_cyc[0]), 64'd60);
    check("pen_cnt_3x18", 64'(pen_cnt[0] - base), 64'd3);
    @(negedge clk);
    check("busy_after_done", 64'(busy_v[0]), 64'd0);
    check("done_single", 64'(done_v[0]), 64'd0);

    // Timing: 29 passes, L=18, a=0 -> result 29 after 580 cycles.
    lat[1] = 18;
    for (int k = 0; k < 29; k++) push_pa(1, W'(k));
    push_exp(1, 1'b0, 32'd29);
    base = pen_cnt[1];
    start_op(1, 32'd0);
    wait_done(1, 700);
    check("lat_29x18", 64'(done_cyc[1] - start_cyc[1]), 64'd580);
    check("pen_cnt_29x18", 64'(pen_cnt[1] - base), 64'd29);

    // Watchdog: pass 2 never answered -> err=1, result=0x11, 65 cycles after 2nd pa_en.
    repeat (2) @(negedge clk);
    mute_at[1] = m_pcnt[1] + 2;
    push_pa(1, 32'h10); push_pa(1, 32'h11);
    push_exp(1, 1'b1, 32'h11);
    start_op(1, 32'h10);
    wait_done(1, 300);
    check("wdog_delay", 64'(done_cyc[1] - last_pen_cyc[1]), 64'd65);
    repeat (3) @(negedge clk);
    inj_val[1] = 32'h99;
    inj_cnt[1] = inj_cnt[1] + 1;
    repeat (10) @(negedge clk);
    check("late_result", 64'(result_v[1]), 64'h11);
    check("late_busy", 64'(busy_v[1]), 64'd0);
    mute_at[1] = 0;

    // Completion coincides with timer==TIMEOUT-1 on every pass (L=64).
    lat[0] = 64;
    push_pa(0, 1); push_pa(0, 2); push_pa(0, 3);
    push_exp(0, 1'b0, 32'd4);
    base = pen_cnt[0];
    start_op(0, 32'd1);
    repeat (30) @(negedge clk);
    a_in_v[0] = 32'h55;              // start while busy: ignored
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 400);
    check("lat_3x64", 64'(done_cyc[0] - start_cyc[0]), 64'd198);
    // Now in the DONE cycle: start here is ignored, held into IDLE it is accepted.
    lat[0] = 18;
    push_pa(0, 32'h20); push_pa(0, 32'h21); push_pa(0, 32'h22);
    push_exp(0, 1'b0, 32'h23);
    a_in_v[0] = 32'h20;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_cyc[0] = cyc;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 200);
    check("lat_after_done", 64'(done_cyc[0] - start_cyc[0]), 64'd60);
    check("pen_cnt_ignore", 64'(pen_cnt[0] - base), 64'd6);

    // Reset during WAIT of pass 1; stray completion afterwards is ignored.
    repeat (2) @(negedge clk);
    push_pa(0, 32'h40);
    start_op(0, 32'h40);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    inj_val[0] = 32'hFFFF;
    inj_cnt[0] = inj_cnt[0] + 1;
    repeat (8) @(negedge clk);
    check("midrst_result", 64'(result_v[0]), 64'd0);
    check("midrst_busy", 64'(busy_v[0]), 64'd0);
    check("midrst_state", 64'(st_v[0]), 64'd0);
    check("midrst_pa_a", 64'(pa_a_v[0]), 64'd0);

    // Every queued expectation must have been consumed.
    check("pa_q0_empty", 64'(pa_q0.size()), 64'd0);
    check("pa_q1_empty", 64'(pa_q1.size()), 64'd0);
    check("exp_q0_empty", 64'(exp_q0.size()), 64'd0);
    check("exp_q1_empty", 64'(exp_q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before limit");
    $fatal(1, "time limit");
  end

endmodule
